// File: rtl/fmdsp_pkg.sv
// Shared mode encodings and signed saturation limits for the FB42DSP MAC datapath.
package fmdsp_pkg;

  typedef enum logic [1:0] {
    MODE_NARROW = 2'b00,
    MODE_MIXED  = 2'b01,
    MODE_FULL   = 2'b10,
    MODE_DOT2   = 2'b11
  } mode_e;

  localparam int LIM_W = 64;

  function automatic logic signed [LIM_W-1:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [LIM_W-1:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fmdsp_delay_line.sv
// Variable-depth (0..MAX_PIPE) delay of a valid-tagged payload; depth only changes when empty.
// Depth 0 is a combinational pass-through; output data holds the last valid beat; no back-pressure.
module fmdsp_delay_line #(
  parameter int DW        = 8,
  parameter int MAX_PIPE  = 4,
  parameter int PIPE_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  input  logic [DW-1:0]        in_dat,
  input  logic [PIPE_BITS-1:0] depth_req,
  output logic                 out_vld,
  output logic [DW-1:0]        out_dat
);

  localparam logic [PIPE_BITS-1:0] DEPTH_MAX = PIPE_BITS'(MAX_PIPE);

  logic [MAX_PIPE:1]      vld_q, vld_d;
  logic [DW-1:0]          dat_q [1:MAX_PIPE];
  logic [DW-1:0]          dat_d [1:MAX_PIPE];
  logic [PIPE_BITS-1:0]   depth_q, depth_d;
  logic [DW-1:0]          hold_q, hold_d;
  logic [PIPE_BITS-1:0]   depth_clamp, depth_eff;
  logic                   busy, sel_vld;
  logic [DW-1:0]          sel_dat;

  always_comb begin
    depth_clamp = (depth_req > DEPTH_MAX) ? DEPTH_MAX : depth_req;
    busy        = |vld_q;
    depth_eff   = busy ? depth_q : depth_clamp;
    depth_d     = depth_eff;

    // Valid bits are not carried past the active depth, so no stale beat can
    // resurface when a deeper setting is adopted later.
    vld_d[1] = in_vld && (depth_eff >= PIPE_BITS'(1));
    dat_d[1] = in_dat;
    for (int k = 2; k <= MAX_PIPE; k++) begin
      vld_d[k] = vld_q[k-1] && (PIPE_BITS'(k) <= depth_eff);
      dat_d[k] = dat_q[k-1];
    end

    sel_vld = in_vld;
    sel_dat = in_dat;
    for (int k = 1; k <= MAX_PIPE; k++) begin
      if (depth_eff == PIPE_BITS'(k)) begin
        sel_vld = vld_q[k];
        sel_dat = dat_q[k];
      end
    end

    out_vld = sel_vld;
    out_dat = sel_vld ? sel_dat : hold_q;
    hold_d  = out_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      depth_q <= '0;
      hold_q  <= '0;
      for (int k = 1; k <= MAX_PIPE; k++) dat_q[k] <= '0;
    end else begin
      vld_q   <= vld_d;
      depth_q <= depth_d;
      hold_q  <= hold_d;
      for (int k = 1; k <= MAX_PIPE; k++) dat_q[k] <= dat_d[k];
    end
  end

endmodule

// File: rtl/fmdsp_mac_pipe.sv
// Multi-channel fracturable MAC with saturation, dot2 mode and programmable 0..MAX_PIPE latency.
// One beat per cycle, never stalls; latency changes take effect only once the pipe has drained.
module fmdsp_mac_pipe
  import fmdsp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_CH     = 4,
  parameter int SHIFT_BITS = 2,
  parameter int MAX_PIPE   = 4,
  parameter int SATURATE   = 1,
  localparam int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PIPE_BITS = $clog2(MAX_PIPE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      aa,
  input  logic [WIDTH-1:0]      bb,
  input  logic [2*WIDTH-1:0]    cc,
  input  logic [1:0]            mode,
  input  logic                  mac,
  input  logic [SHIFT_BITS-1:0] shift_amount,
  input  logic                  shift_dir,
  input  logic [CH_BITS-1:0]    ch_sel,
  input  logic                  acc_clr,
  input  logic [PIPE_BITS-1:0]  pipe_stages,
  output logic                  out_valid,
  output logic [2*WIDTH-1:0]    out,
  output logic [CH_BITS-1:0]    out_ch,
  output logic                  overflow
);

  localparam int W2 = WIDTH / 2;
  localparam int RW = 2 * WIDTH;
  localparam int SW = RW + SHIFT_BITS + 2;
  localparam int PW = CH_BITS + 1 + RW;

  localparam logic signed [SW-1:0] SUM_MAX = SW'(sat_max(RW));
  localparam logic signed [SW-1:0] SUM_MIN = SW'(sat_min(RW));
  localparam logic signed [RW-1:0] RES_MAX = RW'(sat_max(RW));
  localparam logic signed [RW-1:0] RES_MIN = RW'(sat_min(RW));

  logic signed [RW-1:0]  acc_q [NUM_CH];
  logic signed [RW-1:0]  acc_d [NUM_CH];
  logic [NUM_CH-1:0]     live_q, live_d;

  logic signed [W2:0]    a_nar, b_nar;
  logic signed [W2-1:0]  a_lo, a_hi, b_lo, b_hi;
  logic signed [WIDTH-1:0] a_full, b_full;
  logic signed [RW-1:0]  prod;
  logic signed [SW-1:0]  acc_ext, addend, sum;
  logic signed [RW-1:0]  result;
  logic                  ovf, chain;
  logic [PW-1:0]         dl_dat;
  logic                  dl_vld;

  always_comb begin
    a_nar  = aa[W2:0];
    b_nar  = bb[W2:0];
    a_lo   = aa[W2-1:0];
    a_hi   = aa[WIDTH-1:W2];
    b_lo   = bb[W2-1:0];
    b_hi   = bb[WIDTH-1:W2];
    a_full = aa;
    b_full = bb;
    prod   = '0;
    case (mode_e'(mode))
      MODE_NARROW: prod = RW'(a_nar) * RW'(b_nar);
      MODE_MIXED:  prod = RW'(a_nar) * RW'(b_full);
      MODE_FULL:   prod = RW'(a_full) * RW'(b_full);
      MODE_DOT2:   prod = RW'(a_lo) * RW'(b_lo) + RW'(a_hi) * RW'(b_hi);
      default:     prod = '0;
    endcase

    // A clear in the same cycle wins over the stored value: the beat falls back to cc.
    chain   = mac && live_q[ch_sel] && !acc_clr;
    acc_ext = SW'(acc_q[ch_sel]);
    if (chain) addend = shift_dir ? (acc_ext >>> shift_amount) : (acc_ext <<< shift_amount);
    else       addend = SW'($signed(cc));
    sum = SW'(prod) + addend;

    ovf    = 1'b0;
    result = sum[RW-1:0];
    if (sum > SUM_MAX) begin
      ovf = 1'b1;
      if (SATURATE != 0) result = RES_MAX;
    end else if (sum < SUM_MIN) begin
      ovf = 1'b1;
      if (SATURATE != 0) result = RES_MIN;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) acc_d[i] = acc_clr ? '0 : acc_q[i];
    live_d = acc_clr ? '0 : live_q;
    if (in_valid) begin
      acc_d[ch_sel]  = result;
      live_d[ch_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      live_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
      live_q <= live_d;
    end
  end

  fmdsp_delay_line #(
    .DW        (PW),
    .MAX_PIPE  (MAX_PIPE),
    .PIPE_BITS (PIPE_BITS)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (in_valid),
    .in_dat    ({ch_sel, ovf, result}),
    .depth_req (pipe_stages),
    .out_vld   (dl_vld),
    .out_dat   (dl_dat)
  );

  assign out_valid = dl_vld;
  assign out       = dl_dat[RW-1:0];
  assign overflow  = dl_vld & dl_dat[RW];
  assign out_ch    = dl_dat[RW+1 +: CH_BITS];

endmodule
